// File: rtl/alu_issue_if.sv
// Issue-stage bundle: instruction handshake, write-back port, and the operand
// handshake toward the ALU. The slave modport is the issue stage itself.
interface alu_issue_if;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] instr;
    logic        wb_en;
    logic [1:0]  wb_addr;
    logic [7:0]  wb_data;
    logic        ex_valid;
    logic        ex_ready;
    logic [7:0]  alu_a;
    logic [7:0]  alu_b;
    logic [2:0]  alu_ctrl;
    logic [1:0]  ex_rd;
    logic        err;

    modport master (
        output in_valid, instr, wb_en, wb_addr, wb_data, ex_ready,
        input  in_ready, ex_valid, alu_a, alu_b, alu_ctrl, ex_rd, err
    );

    modport slave (
        input  in_valid, instr, wb_en, wb_addr, wb_data, ex_ready,
        output in_ready, ex_valid, alu_a, alu_b, alu_ctrl, ex_rd, err
    );
endinterface

// File: rtl/alu_issue_stage.sv
// ALU issue stage: decode, 4x8 register file, busy scoreboard, registered operands.
// Define ALU_ISSUE_FWD_EN to bypass write-back data into a same-cycle issue.
module alu_issue_stage (
    input logic        clk,
    input logic        rst_n,
    alu_issue_if.slave bus
);
    localparam logic [1:0] OP_NOP = 2'b00;
    localparam logic [1:0] OP_RR  = 2'b01;
    localparam logic [1:0] OP_RI  = 2'b10;
    localparam logic [1:0] OP_ILL = 2'b11;

    logic [3:0][7:0] regs;
    logic [3:0]      busy;

    logic [1:0] op, rd, rs1, rs2;
    logic [2:0] ctrl;
    logic       is_alu, uses_b;
    logic       fwd_a, fwd_b;
    logic       haz_a, haz_b, haz_rd, hazard;
    logic [7:0] val_a, val_b;
    logic       accept;
    logic [3:0] busy_set, busy_clr;

    always_comb begin
        op     = bus.instr[15:14];
        ctrl   = bus.instr[13:11];
        rd     = bus.instr[10:9];
        rs2    = bus.instr[6:5];
        is_alu = (op == OP_RR) || (op == OP_RI);
        uses_b = (op == OP_RR);
        // reg-imm reuses rd as its A source
        rs1    = uses_b ? bus.instr[8:7] : rd;
`ifdef ALU_ISSUE_FWD_EN
        fwd_a = bus.wb_en && (bus.wb_addr == rs1);
        fwd_b = bus.wb_en && (bus.wb_addr == rs2);
`else
        fwd_a = 1'b0;
        fwd_b = 1'b0;
`endif
        val_a  = fwd_a ? bus.wb_data : regs[rs1];
        val_b  = uses_b ? (fwd_b ? bus.wb_data : regs[rs2]) : bus.instr[7:0];
        haz_a  = busy[rs1] && !fwd_a;
        haz_b  = uses_b && busy[rs2] && !fwd_b;
        haz_rd = busy[rd] && !(bus.wb_en && (bus.wb_addr == rd));
        hazard = is_alu && (haz_a || haz_b || haz_rd);
    end

    assign bus.in_ready = (!bus.ex_valid || bus.ex_ready) && !hazard;
    assign accept       = bus.in_valid && bus.in_ready;

    always_comb begin
        busy_set = 4'b0000;
        busy_clr = 4'b0000;
        if (accept && is_alu) busy_set = 4'b0001 << rd;
        if (bus.wb_en)        busy_clr = 4'b0001 << bus.wb_addr;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            regs         <= '0;
            busy         <= '0;
            bus.ex_valid <= 1'b0;
            bus.alu_a    <= '0;
            bus.alu_b    <= '0;
            bus.alu_ctrl <= '0;
            bus.ex_rd    <= '0;
            bus.err      <= 1'b0;
        end else begin
            if (bus.wb_en) regs[bus.wb_addr] <= bus.wb_data;
            // set wins over a same-edge clear of the same bit
            busy <= (busy & ~busy_clr) | busy_set;
            if (accept && is_alu) begin
                bus.ex_valid <= 1'b1;
                bus.alu_a    <= val_a;
                bus.alu_b    <= val_b;
                bus.alu_ctrl <= ctrl;
                bus.ex_rd    <= rd;
            end else if (bus.ex_ready) begin
                bus.ex_valid <= 1'b0;
            end
            if (accept && (op == OP_ILL)) bus.err <= 1'b1;
        end
    end

    // NOP is consumed purely through the handshake
    logic unused_nop;
    assign unused_nop = (op == OP_NOP);
endmodule
